ysyx_23060077_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_23060077_mem_arbiter
// PURPOSE
//  Shares the single memory-side read/write channel pair (toward the AXI bridge) between the
//  IFU (read-only) and the LSU (read or write). One transaction in flight at a time.
//  Grant is registered and held until the last beat completes.
//  Sits between the IFU/LSU and the AXI master bridge.
// PARAMETERS
//  ADDR_WIDTH  32  address width of all channels
//  DATA_WIDTH  32  data width of all channels
//  SIZE_WIDTH  3   AXI size field width
//  LEN_WIDTH   8   AXI len field width
//  RR_EN       1   1: round-robin on conflict; 0: fixed LSU priority
// PORTS
//  clock         in   1   clock
//  reset         in   1   synchronous, active-high reset
//  ifu_r_valid_i in   1   IFU read request; held until ifu_r_ready_o & ifu_r_last_o
//  ifu_r_addr_i  in   AW  IFU read address
//  ifu_r_size_i  in   SW  IFU read size
//  ifu_r_len_i   in   LW  IFU burst length-1
//  ifu_r_ready_o out  1   IFU read beat valid
//  ifu_r_data_o  out  DW  IFU read data
//  ifu_r_last_o  out  1   IFU last read beat
//  lsu_r_*       same set as ifu_r_* (valid/addr/size/len in; ready/data/last out)
//  lsu_w_valid_i in   1   LSU write request; held until lsu_w_last_o
//  lsu_w_addr_i  in   AW  LSU write address
//  lsu_w_data_i  in   DW  LSU write data
//  lsu_w_size_i  in   SW  LSU write size
//  lsu_w_len_i   in   LW  LSU write length-1
//  lsu_w_ready_o out  1   write beat accepted
//  lsu_w_last_o  out  1   write complete
//  mem_r_valid_o/addr_o/size_o/len_o  out  read request to bridge
//  mem_r_ready_i/data_i/last_i        in   read beat from bridge
//  mem_w_valid_o/addr_o/data_o/size_o/len_o  out  write request to bridge
//  mem_w_ready_i/last_i               in   write beat accept / write complete
//  busy_o        out  1   state != IDLE
// BEHAVIOUR
//  Reset: state = IDLE, last_grant = LSU; all outputs 0.
//  FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR.
//  IDLE: sampled at the clock edge.
//   - LSU requests only: lsu_r_valid_i -> LSU_RD; else lsu_w_valid_i -> LSU_WR.
//   - If LSU read and LSU write are both valid: read wins.
//   - IFU requests only: -> IFU_RD.
//   - Both request: RR_EN=1 grants the requester not in last_grant; RR_EN=0 grants LSU.
//   - last_grant is updated on every grant.
//  Latency: request seen in cycle N; mem_*_valid_o first high in cycle N+1.
//  Owned state: mem channel outputs combinationally mirror the granted requester's
//   valid/addr/size/len/data. The other channel's outputs are 0.
//  Response routing: ready/data/last go only to the grantee. Non-granted requesters see 0.
//  Completion:
//   - read: mem_r_ready_i & mem_r_last_i.
//   - write: mem_w_last_i.
//   - On completion, return to IDLE at the next edge.
//   - Minimum one IDLE cycle between transactions.
//  Grant is held until completion even if the grantee drops valid (protocol violation).
//   The bridge then sees valid=0; the arbiter still waits for last.
//  Bridge inputs arriving while IDLE are ignored.
//  Reset mid-transaction: IDLE next cycle; the transaction is abandoned (bridge is reset too).
//  Bursts: multi-beat reads pass every beat; FSM leaves only on the last beat.
// TESTING
//  1. IFU read 0x8000_0000, len=0; bridge returns 0x0000_0413 with last 3 cycles later
//     -> mem_r_valid 1 cycle after request; IFU gets data+last; busy_o drops next cycle.
//  2. IFU and LSU read same cycle, RR_EN=1, last_grant=LSU -> IFU served first, LSU next.
//     With RR_EN=0 -> LSU first.
//  3. LSU write 0xA000_03F8 data 0x41 size 0 -> mem_w_* mirrors inputs.
//     lsu_w_last_o pulses on mem_w_last_i; IFU held off meanwhile.
//  4. IFU burst len=3 -> 4 beats forwarded; FSM stays IFU_RD until 4th beat with last.
//  5. Reset asserted mid LSU_RD -> all outputs 0 next cycle, busy_o=0.
//     A pending IFU request is granted after reset is released.
//  6. Spurious mem_r_ready_i in IDLE -> no ready/last to either requester.

Source files
------------

// File: rtl/ysyx_23060077_mem_arbiter.sv
// rtl/ysyx_23060077_mem_arbiter.sv - shares one memory read/write channel pair between IFU and LSU
// One transaction in flight; grant is registered and held until the completing beat.
module ysyx_23060077_mem_arbiter #(
   parameter int   ADDR_WIDTH = 32,
   parameter int   DATA_WIDTH = 32,
   parameter int   SIZE_WIDTH = 3,
   parameter int   LEN_WIDTH  = 8,
   parameter logic RR_EN      = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ifu_r_valid_i,
   input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
   input  logic [SIZE_WIDTH-1:0] ifu_r_size_i,
   input  logic [LEN_WIDTH-1:0]  ifu_r_len_i,
   output logic                  ifu_r_ready_o,
   output logic [DATA_WIDTH-1:0] ifu_r_data_o,
   output logic                  ifu_r_last_o,
   input  logic                  lsu_r_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
   input  logic [SIZE_WIDTH-1:0] lsu_r_size_i,
   input  logic [LEN_WIDTH-1:0]  lsu_r_len_i,
   output logic                  lsu_r_ready_o,
   output logic [DATA_WIDTH-1:0] lsu_r_data_o,
   output logic                  lsu_r_last_o,
   input  logic                  lsu_w_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_w_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
   input  logic [SIZE_WIDTH-1:0] lsu_w_size_i,
   input  logic [LEN_WIDTH-1:0]  lsu_w_len_i,
   output logic                  lsu_w_ready_o,
   output logic                  lsu_w_last_o,
   output logic                  mem_r_valid_o,
   output logic [ADDR_WIDTH-1:0] mem_r_addr_o,
   output logic [SIZE_WIDTH-1:0] mem_r_size_o,
   output logic [LEN_WIDTH-1:0]  mem_r_len_o,
   input  logic                  mem_r_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_r_data_i,
   input  logic                  mem_r_last_i,
   output logic                  mem_w_valid_o,
   output logic [ADDR_WIDTH-1:0] mem_w_addr_o,
   output logic [DATA_WIDTH-1:0] mem_w_data_o,
   output logic [SIZE_WIDTH-1:0] mem_w_size_o,
   output logic [LEN_WIDTH-1:0]  mem_w_len_o,
   input  logic                  mem_w_ready_i,
   input  logic                  mem_w_last_i,
   output logic                  busy_o
);

   typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

   state_t state;
   logic   last_lsu;
   logic   lsu_req;
   logic   pick_ifu;

   assign lsu_req = lsu_r_valid_i | lsu_w_valid_i;
   // IFU wins a conflict only in round-robin mode when the LSU had the previous grant.
   assign pick_ifu = ifu_r_valid_i & (~lsu_req | (RR_EN & last_lsu));

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         last_lsu <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pick_ifu) begin
                  state    <= IFU_RD;
                  last_lsu <= 1'b0;
               end else if (lsu_req) begin
                  state    <= lsu_r_valid_i ? LSU_RD : LSU_WR;
                  last_lsu <= 1'b1;
               end
            end
            IFU_RD, LSU_RD: if (mem_r_ready_i & mem_r_last_i) state <= IDLE;
            LSU_WR:         if (mem_w_last_i) state <= IDLE;
            default:        state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_r_valid_o = 1'b0;
      mem_r_addr_o  = '0;
      mem_r_size_o  = '0;
      mem_r_len_o   = '0;
      mem_w_valid_o = 1'b0;
      mem_w_addr_o  = '0;
      mem_w_data_o  = '0;
      mem_w_size_o  = '0;
      mem_w_len_o   = '0;
      ifu_r_ready_o = 1'b0;
      ifu_r_data_o  = '0;
      ifu_r_last_o  = 1'b0;
      lsu_r_ready_o = 1'b0;
      lsu_r_data_o  = '0;
      lsu_r_last_o  = 1'b0;
      lsu_w_ready_o = 1'b0;
      lsu_w_last_o  = 1'b0;
      case (state)
         IFU_RD: begin
            mem_r_valid_o = ifu_r_valid_i;
            mem_r_addr_o  = ifu_r_addr_i;
            mem_r_size_o  = ifu_r_size_i;
            mem_r_len_o   = ifu_r_len_i;
            ifu_r_ready_o = mem_r_ready_i;
            ifu_r_data_o  = mem_r_data_i;
            ifu_r_last_o  = mem_r_last_i;
         end
         LSU_RD: begin
            mem_r_valid_o = lsu_r_valid_i;
            mem_r_addr_o  = lsu_r_addr_i;
            mem_r_size_o  = lsu_r_size_i;
            mem_r_len_o   = lsu_r_len_i;
            lsu_r_ready_o = mem_r_ready_i;
            lsu_r_data_o  = mem_r_data_i;
            lsu_r_last_o  = mem_r_last_i;
         end
         LSU_WR: begin
            mem_w_valid_o = lsu_w_valid_i;
            mem_w_addr_o  = lsu_w_addr_i;
            mem_w_data_o  = lsu_w_data_i;
            mem_w_size_o  = lsu_w_size_i;
            mem_w_len_o   = lsu_w_len_i;
            lsu_w_ready_o = mem_w_ready_i;
            lsu_w_last_o  = mem_w_last_i;
         end
         default: ;
      endcase
   end

   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// tb/tb_ysyx_23060077_mem_arbiter.sv - arbiter bench: grant table plus response scoreboard
// A round-robin and a fixed-priority instance share the same stimulus.
module tb_ysyx_23060077_mem_arbiter;
   localparam logic [31:0] IFU_A  = 32'h8000_0000;
   localparam logic [31:0] LSU_RA = 32'h1000_0040;
   localparam logic [31:0] LSU_WA = 32'hA000_03F8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        ifu_r_valid_i, lsu_r_valid_i, lsu_w_valid_i;
   logic [31:0] ifu_r_addr_i, lsu_r_addr_i, lsu_w_addr_i, lsu_w_data_i, mem_r_data_i;
   logic [2:0]  ifu_r_size_i, lsu_r_size_i, lsu_w_size_i;
   logic [7:0]  ifu_r_len_i, lsu_r_len_i, lsu_w_len_i;
   logic        mem_r_ready_i, mem_r_last_i, mem_w_ready_i, mem_w_last_i;

   logic        ifu_r_ready_o, ifu_r_last_o, lsu_r_ready_o, lsu_r_last_o, lsu_w_ready_o, lsu_w_last_o;
   logic [31:0] ifu_r_data_o, lsu_r_data_o, mem_r_addr_o, mem_w_addr_o, mem_w_data_o;
   logic        mem_r_valid_o, mem_w_valid_o, busy_o;
   logic [2:0]  mem_r_size_o, mem_w_size_o;
   logic [7:0]  mem_r_len_o, mem_w_len_o;

   logic        b_ifu_r_ready_o, b_ifu_r_last_o, b_lsu_r_ready_o, b_lsu_r_last_o, b_lsu_w_ready_o, b_lsu_w_last_o;
   logic [31:0] b_ifu_r_data_o, b_lsu_r_data_o, b_mem_r_addr_o, b_mem_w_addr_o, b_mem_w_data_o;
   logic        b_mem_r_valid_o, b_mem_w_valid_o, b_busy_o;
   logic [2:0]  b_mem_r_size_o, b_mem_w_size_o;
   logic [7:0]  b_mem_r_len_o, b_mem_w_len_o;

   ysyx_23060077_mem_arbiter #(.RR_EN(1'b1)) dut (
      .clock(clock), .reset(reset),
      .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_size_i(ifu_r_size_i),
      .ifu_r_len_i(ifu_r_len_i), .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
      .ifu_r_last_o(ifu_r_last_o),
      .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
      .lsu_r_len_i(lsu_r_len_i), .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
      .lsu_r_last_o(lsu_r_last_o),
      .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
      .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i), .lsu_w_ready_o(lsu_w_ready_o),
      .lsu_w_last_o(lsu_w_last_o),
      .mem_r_valid_o(mem_r_valid_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_size_o(mem_r_size_o),
      .mem_r_len_o(mem_r_len_o), .mem_r_ready_i(mem_r_ready_i), .mem_r_data_i(mem_r_data_i),
      .mem_r_last_i(mem_r_last_i),
      .mem_w_valid_o(mem_w_valid_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
      .mem_w_size_o(mem_w_size_o), .mem_w_len_o(mem_w_len_o), .mem_w_ready_i(mem_w_ready_i),
      .mem_w_last_i(mem_w_last_i), .busy_o(busy_o)
   );

   ysyx_23060077_mem_arbiter #(.RR_EN(1'b0)) dut_fix (
      .clock(clock), .reset(reset),
      .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_size_i(ifu_r_size_i),
      .ifu_r_len_i(ifu_r_len_i), .ifu_r_ready_o(b_ifu_r_ready_o), .ifu_r_data_o(b_ifu_r_data_o),
      .ifu_r_last_o(b_ifu_r_last_o),
      .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
      .lsu_r_len_i(lsu_r_len_i), .lsu_r_ready_o(b_lsu_r_ready_o), .lsu_r_data_o(b_lsu_r_data_o),
      .lsu_r_last_o(b_lsu_r_last_o),
      .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
      .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i), .lsu_w_ready_o(b_lsu_w_ready_o),
      .lsu_w_last_o(b_lsu_w_last_o),
      .mem_r_valid_o(b_mem_r_valid_o), .mem_r_addr_o(b_mem_r_addr_o), .mem_r_size_o(b_mem_r_size_o),
      .mem_r_len_o(b_mem_r_len_o), .mem_r_ready_i(mem_r_ready_i), .mem_r_data_i(mem_r_data_i),
      .mem_r_last_i(mem_r_last_i),
      .mem_w_valid_o(b_mem_w_valid_o), .mem_w_addr_o(b_mem_w_addr_o), .mem_w_data_o(b_mem_w_data_o),
      .mem_w_size_o(b_mem_w_size_o), .mem_w_len_o(b_mem_w_len_o), .mem_w_ready_i(mem_w_ready_i),
      .mem_w_last_i(mem_w_last_i), .busy_o(b_busy_o)
   );

   typedef struct packed {logic [1:0] who; logic [31:0] data; logic last;} resp_t;
   typedef struct {logic i; logic r; logic w; logic [2:0] g_rr; logic [2:0] g_fix;} vec_t;

   resp_t exp_q[$];
   resp_t mon_act, mon_exp, e;
   int    mon_n;
   int    errors = 0;
   int    checks = 0;
   vec_t  vt[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // 0 none, 1 IFU read, 2 LSU read, 3 LSU write, 7 inconsistent channel outputs
   function automatic logic [2:0] grant_of(input logic rv, input logic [31:0] ra,
                                           input logic wv, input logic [31:0] wa);
      if (!rv && ra == 32'h0 && !wv && wa == 32'h0) return 3'd0;
      if (rv && ra == IFU_A && !wv && wa == 32'h0) return 3'd1;
      if (rv && ra == LSU_RA && !wv && wa == 32'h0) return 3'd2;
      if (!rv && ra == 32'h0 && wv && wa == LSU_WA) return 3'd3;
      return 3'd7;
   endfunction

   function automatic logic [2:0] g_dut();
      return grant_of(mem_r_valid_o, mem_r_addr_o, mem_w_valid_o, mem_w_addr_o);
   endfunction

   function automatic logic [2:0] g_fix();
      return grant_of(b_mem_r_valid_o, b_mem_r_addr_o, b_mem_w_valid_o, b_mem_w_addr_o);
   endfunction

   function automatic logic [63:0] resp_bits();
      return 64'({ifu_r_ready_o, ifu_r_last_o, lsu_r_ready_o, lsu_r_last_o, lsu_w_ready_o, lsu_w_last_o});
   endfunction

   always @(negedge clock) begin
      if (ifu_r_ready_o | ifu_r_last_o | lsu_r_ready_o | lsu_r_last_o | lsu_w_ready_o | lsu_w_last_o) begin
         mon_n = int'(ifu_r_ready_o | ifu_r_last_o) + int'(lsu_r_ready_o | lsu_r_last_o)
               + int'(lsu_w_ready_o | lsu_w_last_o);
         if (ifu_r_ready_o | ifu_r_last_o) mon_act = '{2'd1, ifu_r_data_o, ifu_r_last_o};
         else if (lsu_r_ready_o | lsu_r_last_o) mon_act = '{2'd2, lsu_r_data_o, lsu_r_last_o};
         else mon_act = '{2'd3, 32'h0, lsu_w_last_o};
         check("resp_single_target", 64'(mon_n), 64'd1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got %0h expected no response", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            check("resp", 64'(mon_act), 64'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input logic i, input logic r, input logic w);
      ifu_r_valid_i = i;
      lsu_r_valid_i = r;
      lsu_w_valid_i = w;
   endtask

   task automatic clear_bridge();
      mem_r_ready_i = 1'b0;
      mem_r_last_i  = 1'b0;
      mem_r_data_i  = 32'h0;
      mem_w_ready_i = 1'b0;
      mem_w_last_i  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_req(1'b0, 1'b0, 1'b0);
      clear_bridge();
      tick();
      reset = 1'b0;
   endtask

   task automatic beat_r(input logic [31:0] d, input logic l, input logic [1:0] who);
      mem_r_ready_i = 1'b1;
      mem_r_data_i  = d;
      mem_r_last_i  = l;
      if (who != 2'd0) begin
         e = '{who, d, l};
         exp_q.push_back(e);
      end
      tick();
      clear_bridge();
   endtask

   task automatic beat_w(input logic l);
      mem_w_ready_i = 1'b1;
      mem_w_last_i  = l;
      e = '{2'd3, 32'h0, l};
      exp_q.push_back(e);
      tick();
      clear_bridge();
   endtask

   initial begin
      ifu_r_addr_i = IFU_A;  ifu_r_size_i = 3'd2; ifu_r_len_i = 8'd0;
      lsu_r_addr_i = LSU_RA; lsu_r_size_i = 3'd2; lsu_r_len_i = 8'd0;
      lsu_w_addr_i = LSU_WA; lsu_w_data_i = 32'h41; lsu_w_size_i = 3'd0; lsu_w_len_i = 8'd0;

      vt[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd1};
      vt[1] = '{1'b0, 1'b1, 1'b0, 3'd2, 3'd2};
      vt[2] = '{1'b0, 1'b0, 1'b1, 3'd3, 3'd3};
      vt[3] = '{1'b0, 1'b1, 1'b1, 3'd2, 3'd2};
      vt[4] = '{1'b1, 1'b1, 1'b0, 3'd1, 3'd2};
      vt[5] = '{1'b1, 1'b0, 1'b1, 3'd1, 3'd3};
      vt[6] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd2};
      vt[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0};

      do_reset();
      check("reset_ctrl", 64'({busy_o, mem_r_valid_o, mem_w_valid_o, b_busy_o}), 64'd0);
      check("reset_resp", resp_bits(), 64'd0);
      check("reset_bus", 64'({mem_r_addr_o, mem_w_addr_o}), 64'd0);

      // grant table: each row starts from reset, so last_grant is LSU
      for (int k = 0; k < 8; k++) begin
         do_reset();
         set_req(vt[k].i, vt[k].r, vt[k].w);
         check($sformatf("tbl%0d_pre_edge", k), 64'(g_dut()), 64'd0);
         tick();
         check($sformatf("tbl%0d_grant_rr", k), 64'(g_dut()), 64'(vt[k].g_rr));
         check($sformatf("tbl%0d_grant_fix", k), 64'(g_fix()), 64'(vt[k].g_fix));
         if (vt[k].g_rr != 3'd0) begin
            mem_r_ready_i = 1'b1;
            mem_r_last_i  = 1'b1;
            mem_r_data_i  = 32'h100 + 32'(k);
            mem_w_ready_i = 1'b1;
            mem_w_last_i  = 1'b1;
            if (vt[k].g_rr == 3'd3) e = '{2'd3, 32'h0, 1'b1};
            else e = '{vt[k].g_rr[1:0], 32'h100 + 32'(k), 1'b1};
            exp_q.push_back(e);
         end
         tick();
         clear_bridge();
         set_req(1'b0, 1'b0, 1'b0);
         check($sformatf("tbl%0d_idle_after", k), 64'({busy_o, b_busy_o}), 64'd0);
      end

      // single IFU fetch with a three-cycle memory latency
      do_reset();
      set_req(1'b1, 1'b0, 1'b0);
      check("fetch_valid_cycle_n", 64'(mem_r_valid_o), 64'd0);
      tick();
      check("fetch_valid_cycle_n1", 64'(g_dut()), 64'd1);
      check("fetch_size", 64'(mem_r_size_o), 64'd2);
      tick();
      tick();
      check("fetch_busy_wait", 64'(busy_o), 64'd1);
      beat_r(32'h0000_0413, 1'b1, 2'd1);
      set_req(1'b0, 1'b0, 1'b0);
      check("fetch_busy_drop", 64'(busy_o), 64'd0);

      // simultaneous reads: round-robin alternates, fixed priority keeps LSU
      do_reset();
      set_req(1'b1, 1'b1, 1'b0);
      tick();
      check("conflict_first_rr", 64'(g_dut()), 64'd1);
      check("conflict_first_fix", 64'(g_fix()), 64'd2);
      beat_r(32'hCAFE_0001, 1'b1, 2'd1);
      check("conflict_gap", 64'({busy_o, b_busy_o}), 64'd0);
      tick();
      check("conflict_second_rr", 64'(g_dut()), 64'd2);
      check("conflict_second_fix", 64'(g_fix()), 64'd2);
      set_req(1'b0, 1'b1, 1'b0);
      beat_r(32'hCAFE_0002, 1'b1, 2'd2);
      set_req(1'b0, 1'b0, 1'b0);

      // LSU byte write while IFU waits
      do_reset();
      set_req(1'b0, 1'b0, 1'b1);
      tick();
      check("wr_grant", 64'(g_dut()), 64'd3);
      check("wr_mirror", 64'({mem_w_data_o, mem_w_size_o, mem_w_len_o}), 64'({32'h41, 3'd0, 8'd0}));
      ifu_r_valid_i = 1'b1;
      tick();
      check("wr_ifu_held", 64'({mem_r_valid_o, busy_o}), 64'b01);
      beat_w(1'b0);
      check("wr_ifu_held2", 64'(mem_r_valid_o), 64'd0);
      beat_w(1'b1);
      lsu_w_valid_i = 1'b0;
      check("wr_idle_gap", 64'({busy_o, mem_r_valid_o}), 64'd0);
      tick();
      check("wr_then_ifu", 64'(g_dut()), 64'd1);
      beat_r(32'h1234_5678, 1'b1, 2'd1);
      set_req(1'b0, 1'b0, 1'b0);

      // four-beat IFU burst
      do_reset();
      ifu_r_len_i = 8'd3;
      set_req(1'b1, 1'b0, 1'b0);
      tick();
      check("burst_len", 64'(mem_r_len_o), 64'd3);
      for (int k = 0; k < 4; k++) begin
         beat_r(32'hB000_0000 + 32'(k), k == 3, 2'd1);
         check($sformatf("burst_busy_beat%0d", k), 64'(busy_o), (k < 3) ? 64'd1 : 64'd0);
      end
      set_req(1'b0, 1'b0, 1'b0);
      ifu_r_len_i = 8'd0;

      // reset during an LSU read, IFU pending
      do_reset();
      set_req(1'b0, 1'b1, 1'b0);
      tick();
      check("rst_mid_grant", 64'(g_dut()), 64'd2);
      ifu_r_valid_i = 1'b1;
      reset = 1'b1;
      tick();
      check("rst_mid_outputs", 64'({busy_o, g_dut()}), 64'd0);
      check("rst_mid_resp", resp_bits(), 64'd0);
      reset = 1'b0;
      lsu_r_valid_i = 1'b0;
      tick();
      check("rst_then_ifu", 64'(g_dut()), 64'd1);
      beat_r(32'h0BAD_F00D, 1'b1, 2'd1);
      set_req(1'b0, 1'b0, 1'b0);

      // spurious bridge responses while idle
      tick();
      mem_r_ready_i = 1'b1;
      mem_r_last_i  = 1'b1;
      mem_r_data_i  = 32'hDEAD_BEEF;
      mem_w_ready_i = 1'b1;
      mem_w_last_i  = 1'b1;
      @(negedge clock);
      check("spurious_resp", resp_bits(), 64'd0);
      check("spurious_data", 64'({ifu_r_data_o, lsu_r_data_o}), 64'd0);
      tick();
      clear_bridge();
      check("spurious_busy", 64'(busy_o), 64'd0);

      tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
